// File: rtl/seq_player.sv
// seq_player: steps through the current round's colour sequence, showing each
// ROM entry on the LEDs for ON_TICKS ticks followed by GAP_TICKS ticks of blank,
// then holds end_fpga until the controller drops its play enable.
module seq_player #(
  parameter int N_STEPS   = 16,
  parameter int ADDR_W    = 4,
  parameter int CODE_W    = 4,
  parameter int ROUND_W   = 4,
  parameter int ON_TICKS  = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [ROUND_W-1:0] round,
  input  logic               tick,
  input  logic [CODE_W-1:0]  seq_data,
  output logic [ADDR_W-1:0]  seq_addr,
  output logic [CODE_W-1:0]  leds,
  output logic               busy,
  output logic               end_fpga
);

  localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [LEN_W-1:0]   len;
  logic [TW-1:0]      tcnt;

  // round+1 carries an extra bit so the largest round never wraps to zero steps
  logic [ROUND_W:0]   round_p1;
  logic [LEN_W-1:0]   start_len;
  logic               last_step;

  // Saturate the requested length to the ROM depth and flag the final step
  always_comb begin
    round_p1 = {1'b0, round} + {{ROUND_W{1'b0}}, 1'b1};
    if (int'(round_p1) > N_STEPS) start_len = LEN_W'(N_STEPS);
    else                          start_len = LEN_W'(round_p1);
    last_step = ({1'b0, idx} == (len - LEN_W'(1)));
  end

  // Playback FSM; every output is a register, abort on enable low wins over all else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      leds     <= '0;
      seq_addr <= '0;
      end_fpga <= 1'b0;
      busy     <= 1'b0;
      idx      <= '0;
      len      <= '0;
      tcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            len      <= start_len;
            idx      <= '0;
            seq_addr <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH, SHOW, GAP: begin
          if (!enable) begin
            leds     <= '0;
            seq_addr <= '0;
            tcnt     <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (state == FETCH) begin
            leds  <= seq_data;
            tcnt  <= '0;
            state <= SHOW;
          end else if (state == SHOW) begin
            if (tick) begin
              if (tcnt == TW'(ON_TICKS - 1)) begin
                leds  <= '0;
                tcnt  <= '0;
                state <= GAP;
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end
          end else begin
            if (tick) begin
              if (tcnt == TW'(GAP_TICKS - 1)) begin
                tcnt <= '0;
                if (last_step) begin
                  end_fpga <= 1'b1;
                  state    <= DONE;
                end else begin
                  idx      <= idx + ADDR_W'(1);
                  seq_addr <= idx + ADDR_W'(1);
                  state    <= FETCH;
                end
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end
          end
        end
        DONE: begin
          leds <= '0;
          if (!enable) begin
            end_fpga <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          leds     <= '0;
          seq_addr <= '0;
          end_fpga <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
